// File: rtl/bitstream_packer.sv
// MSB-first JPEG bit packer with 0xFF/0x00 stuffing and 1-padded frame flush.
// Define BS_BYTE_CNT_EN to add the per-frame bs_byte_cnt output.
module bitstream_packer #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6,
  parameter int ACC_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bs_load_i,
  input  logic [DATA_W-1:0] bs_data_in_i,
  input  logic [LEN_W-1:0]  bs_data_len_i,
  input  logic              ee_frame_ready_i,
  output logic              data_valid,
  output logic [7:0]        data_out,
  output logic              bs_frame_ready,
`ifdef BS_BYTE_CNT_EN
  output logic [31:0]       bs_byte_cnt,
`endif
  output logic              err_o
);

  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam int SUM_W = $clog2(ACC_W + (1 << LEN_W));
  localparam logic [CNT_W-1:0] EIGHT = CNT_W'(8);
  localparam logic [SUM_W-1:0] CAP   = SUM_W'(ACC_W);

  logic [ACC_W-1:0]  acc_q, acc_d, acc_sh, ld_bits;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_sh;
  logic [SUM_W-1:0]  sum, shamt;
  logic [DATA_W-1:0] mask;
  logic [7:0]        top, pad;
  logic [7:0]        data_q, data_d;
  logic              stuff_q, stuff_d;
  logic              flush_q, flush_d;
  logic              valid_q, valid_d;
  logic              frame_q, frame_d;
  logic              err_q, err_d;
  logic              ld, fin;

  assign top     = acc_q[ACC_W-1 -: 8];
  assign pad     = top | (8'hFF >> cnt_q);
  assign ld      = bs_load_i && (bs_data_len_i != '0);
  assign mask    = ~({DATA_W{1'b1}} << bs_data_len_i);
  assign sum     = SUM_W'(cnt_sh) + SUM_W'(bs_data_len_i);
  assign shamt   = CAP - sum;
  assign ld_bits = {{(ACC_W-DATA_W){1'b0}},
                    bs_data_in_i & mask} << shamt;

  // Emission decision uses only registered state.
  always_comb begin
    acc_sh  = acc_q;
    cnt_sh  = cnt_q;
    stuff_d = stuff_q;
    data_d  = data_q;
    valid_d = 1'b0;
    fin     = 1'b0;
    if (stuff_q) begin
      data_d  = 8'h00;
      valid_d = 1'b1;
      stuff_d = 1'b0;
    end else if (cnt_q >= EIGHT) begin
      data_d  = top;
      valid_d = 1'b1;
      acc_sh  = acc_q << 8;
      cnt_sh  = cnt_q - EIGHT;
      stuff_d = &top;
    end else if (flush_q && cnt_q != '0) begin
      data_d  = pad;
      valid_d = 1'b1;
      acc_sh  = '0;
      cnt_sh  = '0;
      stuff_d = &pad;
    end else if (flush_q) begin
      fin    = 1'b1;
      acc_sh = '0;
    end
  end

  always_comb begin
    acc_d   = acc_sh;
    cnt_d   = cnt_sh;
    err_d   = err_q;
    flush_d = flush_q & ~fin;
    frame_d = fin;
    if (ld) begin
      if (flush_q || sum > CAP) begin
        err_d = 1'b1;
      end else begin
        acc_d = acc_sh | ld_bits;
        cnt_d = sum[CNT_W-1:0];
      end
    end
    // An empty frame completes without entering flush.
    if (ee_frame_ready_i && !flush_q) begin
      if (!ld && !stuff_q && cnt_q == '0)
        frame_d = 1'b1;
      else
        flush_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      stuff_q <= 1'b0;
      flush_q <= 1'b0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      stuff_q <= stuff_d;
      flush_q <= flush_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  assign data_valid     = valid_q;
  assign data_out       = data_q;
  assign bs_frame_ready = frame_q;
  assign err_o          = err_q;

`ifdef BS_BYTE_CNT_EN
  logic [31:0] bc_q, bc_d;

  assign bc_d = frame_q ? 32'd0 : bc_q + {31'd0, valid_d};

  always_ff @(posedge clk) begin
    if (rst) bc_q <= '0;
    else     bc_q <= bc_d;
  end

  assign bs_byte_cnt = bc_q;
`endif

endmodule

// File: tb/tb_bitstream_packer.sv
// Scoreboard bench for bitstream_packer: a bit-queue model predicts the
// byte/frame token stream; a negedge monitor pops and compares.
module tb_bitstream_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        bs_load_i;
  logic [31:0] bs_data_in_i;
  logic [5:0]  bs_data_len_i;
  logic        ee_frame_ready_i;
  logic        data_valid;
  logic [7:0]  data_out;
  logic        bs_frame_ready;
  logic        err_o;
`ifdef BS_BYTE_CNT_EN
  logic [31:0] bs_byte_cnt;
`endif

  always #5 clk = ~clk;

  bitstream_packer dut (
    .clk              (clk),
    .rst              (rst),
    .bs_load_i        (bs_load_i),
    .bs_data_in_i     (bs_data_in_i),
    .bs_data_len_i    (bs_data_len_i),
    .ee_frame_ready_i (ee_frame_ready_i),
    .data_valid       (data_valid),
    .data_out         (data_out),
    .bs_frame_ready   (bs_frame_ready),
`ifdef BS_BYTE_CNT_EN
    .bs_byte_cnt      (bs_byte_cnt),
`endif
    .err_o            (err_o)
  );

  int total = 0;
  int bad   = 0;
  int bc_m  = 0;

  // Tokens: 9'h0xx = byte, 9'h100 = frame-done pulse.
  logic [8:0] exp_q[$];
  bit         mbits[$];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               nm, got, want, $time);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    exp_q.push_back({1'b0, b});
    if (b == 8'hFF) exp_q.push_back(9'h000);
  endtask

  task automatic model_load(input logic [31:0] d, input int len);
    logic [7:0] b;
    for (int i = len - 1; i >= 0; i--) mbits.push_back(d[i]);
    while (mbits.size() >= 8) begin
      b = 8'h00;
      for (int j = 0; j < 8; j++) b = {b[6:0], mbits.pop_front()};
      push_byte(b);
    end
  endtask

  task automatic model_frame();
    logic [7:0] b;
    if (mbits.size() > 0) begin
      b = 8'hFF;
      for (int i = 0; i < mbits.size(); i++) b[7-i] = mbits[i];
      mbits.delete();
      push_byte(b);
    end
    exp_q.push_back(9'h100);
  endtask

  task automatic drive(input logic ld, input logic [31:0] d,
                       input logic [5:0] len, input logic ee);
    @(negedge clk);
    bs_load_i        = ld;
    bs_data_in_i     = d;
    bs_data_len_i    = len;
    ee_frame_ready_i = ee;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 6'd0, 1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) idle(1);
    chk("drain", exp_q.size(), 0);
    idle(2);
  endtask

  always @(negedge clk) begin
    logic [8:0] tok;
    if (data_valid === 1'b1) begin
      tok = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1FF;
      chk("byte", {24'd0, data_out}, {23'd0, tok});
      bc_m++;
    end
    if (bs_frame_ready === 1'b1) begin
      tok = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1FF;
      chk("frame", {23'd0, bs_frame_ready, 8'h00}, {23'd0, tok});
`ifdef BS_BYTE_CNT_EN
      chk("byte_cnt", bs_byte_cnt, bc_m);
`endif
      bc_m = 0;
    end
  end

  initial begin
    logic [31:0] d;
    int          len;
    int          nl;
    bit          ee_now;

    rst = 1'b1;
    bs_load_i = 1'b0;
    bs_data_in_i = '0;
    bs_data_len_i = '0;
    ee_frame_ready_i = 1'b0;
    idle(3);
    chk("rst_valid", data_valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_frame", bs_frame_ready, 0);
    chk("rst_err", err_o, 0);
`ifdef BS_BYTE_CNT_EN
    chk("rst_bcnt", bs_byte_cnt, 0);
`endif
    rst = 1'b0;
    idle(1);

    // Two nibbles make one byte and nothing else.
    drive(1'b1, 32'hFFFF_FFFA, 6'd4, 1'b0);
    model_load(32'hA, 4);
    drive(1'b1, 32'h0000_00FF, 6'd4, 1'b0);
    model_load(32'hF, 4);
    idle(6);
    chk("a_one_byte", exp_q.size(), 0);
    drive(1'b0, 32'd0, 6'd0, 1'b1);
    model_frame();
    drain();

    // 0xFF gets a stuffed zero.
    drive(1'b1, 32'h1234_56FF, 6'd8, 1'b0);
    model_load(32'hFF, 8);
    drive(1'b0, 32'd0, 6'd0, 1'b1);
    model_frame();
    drain();

    // Load and frame end together: padded byte then pulse.
    drive(1'b1, 32'h0000_0005, 6'd3, 1'b1);
    model_load(32'h5, 3);
    model_frame();
    for (int k = 0; k < 10 && data_valid !== 1'b1; k++) idle(1);
    chk("c_pad", data_out, 32'hBF);
    idle(1);
    chk("c_frame_next", bs_frame_ready, 1);
    drain();

    // Padding produces 0xFF, stuffed, then pulse.
    drive(1'b1, 32'hFFFF_FF1F, 6'd5, 1'b0);
    model_load(32'h1F, 5);
    drive(1'b0, 32'd0, 6'd0, 1'b1);
    model_frame();
    for (int k = 0; k < 10 && data_valid !== 1'b1; k++) idle(1);
    chk("d_ff", data_out, 32'hFF);
    idle(1);
    chk("d_stuff", {31'd0, data_valid, data_out}, 32'h100);
    idle(1);
    chk("d_frame", bs_frame_ready, 1);
`ifdef BS_BYTE_CNT_EN
    chk("d_bcnt", bs_byte_cnt, 2);
    idle(1);
    chk("d_bcnt_clr", bs_byte_cnt, 0);
`endif
    drain();

    // Random frames, rate-limited so the accumulator never overflows.
    for (int f = 0; f < 25; f++) begin
      nl = $urandom_range(1, 10);
      ee_now = 1'b0;
      for (int i = 0; i < nl; i++) begin
        d = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : $urandom();
        len = $urandom_range(1, 32);
        if ($urandom_range(0, 15) == 0) len = 0;
        ee_now = (i == nl - 1) && ($urandom_range(0, 1) == 1);
        drive(1'b1, d, 6'(len), ee_now);
        model_load(d, len);
        if (ee_now) model_frame();
        idle(2 * ((len + 7) / 8));
      end
      if (!ee_now) begin
        drive(1'b0, 32'd0, 6'd0, 1'b1);
        model_frame();
      end
      drain();
    end
    chk("rand_no_err", err_o, 0);

    // Third back-to-back 32-bit load overflows and is dropped.
    drive(1'b1, 32'h1234_5678, 6'd32, 1'b0);
    model_load(32'h1234_5678, 32);
    drive(1'b1, 32'h9ABC_DEF0, 6'd32, 1'b0);
    model_load(32'h9ABC_DEF0, 32);
    drive(1'b1, 32'hCAFE_BABE, 6'd32, 1'b0);
    idle(2);
    chk("ovf_err", err_o, 1);
    drive(1'b0, 32'd0, 6'd0, 1'b1);
    model_frame();
    drain();
    chk("ovf_err_sticky", err_o, 1);

    // Reset with 13 bits pending discards them.
    drive(1'b1, 32'h0000_1ABC, 6'd13, 1'b0);
    idle(1);
    rst = 1'b1;
    mbits.delete();
    exp_q.delete();
    bc_m = 0;
    drive(1'b0, 32'd0, 6'd0, 1'b1);
    rst = 1'b0;
    chk("mid_rst_valid", data_valid, 0);
    chk("mid_rst_data", data_out, 0);
    chk("mid_rst_frame", bs_frame_ready, 0);
    chk("mid_rst_err", err_o, 0);
    model_frame();
    idle(1);
    chk("mid_rst_pulse", bs_frame_ready, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
